// File: rtl/snake_vram_if.sv
// Tile-map RAM sharing bus: display fetch, game write/read, clear control and the RAM port itself.
interface snake_vram_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 2
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_rvalid;
    logic [DATA_W-1:0] rd_rdata;
    logic              clr_start;
    logic              clr_busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Surrounding system: VGA block, game FSM and the RAM macro
    modport master (
        output disp_req, disp_addr, wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, ram_rdata,
        input  disp_rvalid, disp_rdata, wr_ack, rd_ack, rd_rvalid, rd_rdata, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  disp_req, disp_addr, wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, ram_rdata,
        output disp_rvalid, disp_rdata, wr_ack, rd_ack, rd_rvalid, rd_rdata, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/snake_vram_arbiter.sv
// Single-port tile-map RAM arbiter: display > clear engine > round-robin game write/read.
module snake_vram_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 768
) (
    input  logic         clk_100mhz,
    input  logic         RST,
    snake_vram_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              rd_pri_q, rd_pri_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              rd_rvalid_q, rd_rvalid_d;
    logic              rd_oob_q, rd_oob_d;
    logic              wr_in_range, rd_in_range;

    assign wr_in_range = (bus.wr_addr <= LAST_ADDR);
    assign rd_in_range = (bus.rd_addr <= LAST_ADDR);

    // Grant selection and clear sequencing; nothing is granted while reset is asserted
    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        rd_pri_d      = rd_pri_q;
        disp_rvalid_d = 1'b0;
        rd_rvalid_d   = 1'b0;
        rd_oob_d      = 1'b0;
        bus.wr_ack    = 1'b0;
        bus.rd_ack    = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (!RST) begin
            if (bus.disp_req) begin
                bus.ram_en    = 1'b1;
                bus.ram_addr  = bus.disp_addr;
                disp_rvalid_d = 1'b1;
            end else if (state_q == ST_CLEAR) begin
                bus.ram_en   = 1'b1;
                bus.ram_we   = 1'b1;
                bus.ram_addr = clr_ptr_q;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end else if (bus.wr_req && !(bus.rd_req && rd_pri_q)) begin
                bus.wr_ack    = 1'b1;
                bus.ram_en    = wr_in_range;
                bus.ram_we    = wr_in_range;
                bus.ram_addr  = bus.wr_addr;
                bus.ram_wdata = bus.wr_data;
                rd_pri_d      = 1'b1;
            end else if (bus.rd_req) begin
                bus.rd_ack   = 1'b1;
                bus.ram_en   = rd_in_range;
                bus.ram_addr = bus.rd_addr;
                rd_rvalid_d  = 1'b1;
                rd_oob_d     = !rd_in_range;
                rd_pri_d     = 1'b0;
            end
            if ((state_q == ST_IDLE) && bus.clr_start) begin
                state_d = ST_CLEAR;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            clr_ptr_q     <= '0;
            rd_pri_q      <= 1'b0;
            disp_rvalid_q <= 1'b0;
            rd_rvalid_q   <= 1'b0;
            rd_oob_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            rd_pri_q      <= rd_pri_d;
            disp_rvalid_q <= disp_rvalid_d;
            rd_rvalid_q   <= rd_rvalid_d;
            rd_oob_q      <= rd_oob_d;
        end
    end

    // Out-of-range reads never touched the RAM, so its stale output is masked to zero
    assign bus.clr_busy    = (state_q == ST_CLEAR);
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = disp_rvalid_q ? bus.ram_rdata : '0;
    assign bus.rd_rvalid   = rd_rvalid_q;
    assign bus.rd_rdata    = (rd_rvalid_q && !rd_oob_q) ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_snake_vram_arbiter.sv
// Self-checking bench for snake_vram_arbiter with a behavioural RAM and a map-level reference model.
module tb_snake_vram_arbiter;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 2;
    localparam int unsigned DEPTH  = 768;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    snake_vram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    snake_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk_100mhz (clk),
        .RST        (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency
    logic [DATA_W-1:0] ram [1024];
    logic [DATA_W-1:0] ram_q = '0;
    initial for (int i = 0; i < 1024; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            ram_q <= ram[bus.ram_addr];
        end
    end
    assign bus.ram_rdata = ram_q;

    // Expected map contents
    logic [DATA_W-1:0] exp_mem [DEPTH];

    typedef struct packed {
        logic disp, wr, rd;
        logic e_wa, e_ra, e_en, e_we, e_dv, e_rv;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_req = 0; bus.disp_addr = '0;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.clr_start = 0;
    endtask

    function automatic logic [DATA_W-1:0] fill_val(input int i);
        return DATA_W'((i % 3) + 1);
    endfunction

    task automatic fill_map();
        int nack = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cyc();
            bus.wr_req = 1; bus.wr_addr = ADDR_W'(i); bus.wr_data = fill_val(i);
            #4;
            if (bus.wr_ack !== 1'b1 || bus.ram_we !== 1'b1) nack++;
            exp_mem[i] = fill_val(i);
        end
        cyc();
        bus.wr_req = 0;
        chk("fill_acks", nack, 0);
    endtask

    task automatic readback(input string name);
        int nbad = 0;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            cyc();
            bus.disp_req  = (i < int'(DEPTH));
            bus.disp_addr = ADDR_W'(i % int'(DEPTH));
            #4;
            if (i > 0 && (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== exp_mem[i-1])) nbad++;
        end
        chk(name, nbad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [22:0] outs;
        logic rd_turn, pd_v, pr_v, g_disp, g_wr, g_rd, wr_in, rd_in, exp_en;
        logic [DATA_W-1:0] pd_d, pr_d;
        logic [ADDR_W-1:0] exp_addr;
        int busy, acks, k;

        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
        rst = 1;
        idle_inputs();

        // Reset holds every output at zero
        for (int i = 0; i < 3; i++) begin
            cyc(); #4;
            outs = {bus.disp_rvalid, bus.disp_rdata, bus.wr_ack, bus.rd_ack, bus.rd_rvalid, bus.rd_rdata,
                    bus.clr_busy, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};
            chk("reset_outs", 32'(outs), 0);
        end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #4;
            chk("idle_ram_en", 32'(bus.ram_en), 0);
        end

        // Single write then read-back
        cyc(); bus.wr_req = 1; bus.wr_addr = 10'd37; bus.wr_data = 2'd3; #4;
        chk("wr_ack", 32'(bus.wr_ack), 1);
        chk("wr_ram_we", 32'(bus.ram_we), 1);
        chk("wr_ram_addr", 32'(bus.ram_addr), 37);
        chk("wr_ram_wdata", 32'(bus.ram_wdata), 3);
        exp_mem[37] = 2'd3;
        cyc(); bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = 10'd37; #4;
        chk("rd_ack", 32'(bus.rd_ack), 1);
        chk("rd_ram_en_we", 32'({bus.ram_en, bus.ram_we}), 2);
        cyc(); bus.rd_req = 0; #4;
        chk("rd_rvalid", 32'(bus.rd_rvalid), 1);
        chk("rd_rdata", 32'(bus.rd_rdata), 3);

        // Vector table: round-robin W,R,W,R then display starving a held write
        tbl[0] = '{0,1,1, 1,0,1,1, 0,0};
        tbl[1] = '{0,1,1, 0,1,1,0, 0,0};
        tbl[2] = '{0,1,1, 1,0,1,1, 0,1};
        tbl[3] = '{0,1,1, 0,1,1,0, 0,0};
        tbl[4] = '{1,1,0, 0,0,1,0, 0,1};
        for (int i = 5; i < 14; i++) tbl[i] = '{1,1,0, 0,0,1,0, 1,0};
        tbl[14] = '{0,1,0, 1,0,1,1, 1,0};
        tbl[15] = '{0,0,0, 0,0,0,0, 0,0};
        for (int i = 0; i < 16; i++) begin
            cyc();
            bus.disp_req = tbl[i].disp; bus.disp_addr = 10'd37;
            bus.wr_req = tbl[i].wr; bus.wr_addr = 10'd37; bus.wr_data = 2'd3;
            bus.rd_req = tbl[i].rd; bus.rd_addr = 10'd37;
            #4;
            chk($sformatf("tbl%0d_acks", i), 32'({bus.wr_ack, bus.rd_ack}), 32'({tbl[i].e_wa, tbl[i].e_ra}));
            chk($sformatf("tbl%0d_ram", i), 32'({bus.ram_en, bus.ram_we}), 32'({tbl[i].e_en, tbl[i].e_we}));
            chk($sformatf("tbl%0d_valids", i), 32'({bus.disp_rvalid, bus.rd_rvalid}),
                32'({tbl[i].e_dv, tbl[i].e_rv}));
            if (tbl[i].e_dv) chk($sformatf("tbl%0d_disp_rdata", i), 32'(bus.disp_rdata), 3);
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_rd_rdata", i), 32'(bus.rd_rdata), 3);
        end

        // Randomized traffic against the reference model; last grant was a write so read has priority
        rd_turn = 1; pd_v = 0; pr_v = 0; pd_d = '0; pr_d = '0;
        g_wr = 0; g_rd = 0;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (!bus.wr_req || g_wr) begin
                bus.wr_req  = 1'($urandom_range(0, 1));
                bus.wr_addr = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(768, 1023))
                                                          : ADDR_W'($urandom_range(0, 767));
                bus.wr_data = DATA_W'($urandom);
            end
            if (!bus.rd_req || g_rd) begin
                bus.rd_req  = 1'($urandom_range(0, 1));
                bus.rd_addr = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(768, 1023))
                                                          : ADDR_W'($urandom_range(0, 767));
            end
            bus.disp_req  = ($urandom_range(0, 2) == 0);
            bus.disp_addr = ADDR_W'($urandom_range(0, 767));
            g_disp = bus.disp_req;
            g_wr   = !g_disp && bus.wr_req && (!bus.rd_req || !rd_turn);
            g_rd   = !g_disp && bus.rd_req && !g_wr;
            wr_in  = (int'(bus.wr_addr) < int'(DEPTH));
            rd_in  = (int'(bus.rd_addr) < int'(DEPTH));
            exp_en = g_disp || (g_wr && wr_in) || (g_rd && rd_in);
            exp_addr = g_disp ? bus.disp_addr : (g_wr ? bus.wr_addr : bus.rd_addr);
            #4;
            chk("rnd_wr_ack", 32'(bus.wr_ack), 32'(g_wr));
            chk("rnd_rd_ack", 32'(bus.rd_ack), 32'(g_rd));
            chk("rnd_ram_en", 32'(bus.ram_en), 32'(exp_en));
            chk("rnd_ram_we", 32'(bus.ram_we), 32'(g_wr && wr_in));
            if (exp_en) chk("rnd_ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
            if (g_wr && wr_in) chk("rnd_ram_wdata", 32'(bus.ram_wdata), 32'(bus.wr_data));
            chk("rnd_disp_rvalid", 32'(bus.disp_rvalid), 32'(pd_v));
            if (pd_v) chk("rnd_disp_rdata", 32'(bus.disp_rdata), 32'(pd_d));
            chk("rnd_rd_rvalid", 32'(bus.rd_rvalid), 32'(pr_v));
            if (pr_v) chk("rnd_rd_rdata", 32'(bus.rd_rdata), 32'(pr_d));
            pd_v = g_disp; pd_d = exp_mem[int'(bus.disp_addr) % int'(DEPTH)];
            pr_v = g_rd;   pr_d = rd_in ? exp_mem[int'(bus.rd_addr) % int'(DEPTH)] : '0;
            if (g_wr && wr_in) exp_mem[bus.wr_addr] = bus.wr_data;
            if (g_wr) rd_turn = 1;
            if (g_rd) rd_turn = 0;
        end
        cyc(); idle_inputs();
        cyc();

        // Full clear with display at 50% duty and game requests held
        fill_map();
        cyc(); bus.clr_start = 1; #4;
        chk("clr_start_busy_lag", 32'(bus.clr_busy), 0);
        cyc(); bus.clr_start = 0;
        bus.rd_req = 1; bus.rd_addr = 10'd5;
        bus.wr_req = 1; bus.wr_addr = 10'd800; bus.wr_data = 2'd1;
        busy = 0; acks = 0; k = 0;
        forever begin
            bus.disp_req  = (k % 2 == 0);
            bus.disp_addr = ADDR_W'(k % int'(DEPTH));
            bus.clr_start = (k == 500);
            #4;
            if (!bus.clr_busy || k > 4000) break;
            busy++;
            if (bus.wr_ack || bus.rd_ack) acks++;
            k++;
            cyc();
        end
        chk("clr_terminated", 32'(bus.clr_busy), 0);
        chk("clr_busy_cycles", busy, 1536);
        chk("clr_game_acks", acks, 0);
        cyc(); idle_inputs();
        cyc();
        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
        readback("clear_readback");

        // Reset during clear at pointer 100
        fill_map();
        cyc(); bus.clr_start = 1; bus.wr_req = 1; bus.wr_addr = 10'd10; bus.wr_data = 2'd2; #4;
        chk("clr_start_game_wr", 32'(bus.wr_ack), 1);
        cyc(); bus.clr_start = 0; bus.wr_req = 0; #4;
        chk("clr_busy_set", 32'(bus.clr_busy), 1);
        chk("clr_first_addr", 32'({bus.ram_we, bus.ram_addr}), 32'({1'b1, 10'd0}));
        for (int i = 1; i < 100; i++) cyc();
        cyc(); rst = 1; bus.disp_req = 1; bus.disp_addr = 10'd150; #4;
        chk("rst_no_access", 32'(bus.ram_en), 0);
        cyc(); rst = 0; bus.disp_req = 0; #4;
        chk("rst_clr_busy", 32'(bus.clr_busy), 0);
        chk("rst_disp_rvalid", 32'(bus.disp_rvalid), 0);
        for (int i = 0; i < 100; i++) exp_mem[i] = '0;
        readback("partial_clear_readback");

        // Out-of-range read returns zero even though the RAM output is nonzero
        cyc(); bus.disp_req = 0; bus.rd_req = 1; bus.rd_addr = 10'd800; #4;
        chk("oob_rd_ack", 32'(bus.rd_ack), 1);
        chk("oob_rd_no_ram", 32'(bus.ram_en), 0);
        cyc(); bus.rd_req = 0; #4;
        chk("oob_rd_rvalid", 32'(bus.rd_rvalid), 1);
        chk("oob_rd_rdata", 32'(bus.rd_rdata), 0);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
